// File: rtl/matmul_pool_engine.sv
// matmul_pool_engine: NxN unsigned matrix multiply with per-element saturation,
// followed by 2x2 average/max pooling and row-by-row write-back of the result.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// RD_A  | read strobe for A row i
// CAP_A | capture A row i into the row buffer
// RD_B  | read strobe for B column j
// CAP_B | capture B column j, clear the accumulator
// MAC   | N multiply-accumulate cycles, last one stores C[i][j]
// POOL  | one pooled element per cycle, raster order
// WRITE | one packed pooled row per cycle
// DONE  | single-cycle done pulse
module matmul_pool_engine #(
    parameter int                N      = 4,
    parameter int                DW     = 8,
    parameter int                ACC_W  = 2*DW+4,
    parameter int                ADDR_W = 10,
    parameter logic [ADDR_W-1:0] BASE_A = 10'h000,
    parameter logic [ADDR_W-1:0] BASE_B = 10'h100,
    parameter logic [ADDR_W-1:0] BASE_C = 10'h200
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  pool_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en_a,
    output logic [ADDR_W-1:0]     rd_addr_a,
    input  logic [N*DW-1:0]       rd_data_a,
    output logic                  rd_en_b,
    output logic [ADDR_W-1:0]     rd_addr_b,
    input  logic [N*DW-1:0]       rd_data_b,
    output logic                  wr_en_c,
    output logic [ADDR_W-1:0]     wr_addr_c,
    output logic [(N/2)*DW-1:0]   wr_data_c
);
    localparam int H  = N / 2;
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam int HW = (H > 2) ? $clog2(H) : 1;
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DW) - 1);

    typedef enum logic [3:0] {IDLE, RD_A, CAP_A, RD_B, CAP_B, MAC, POOL, WRITE, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      i, j, k;
    logic [HW-1:0]      pr, pc, wrow;
    logic               mode;
    logic [ACC_W-1:0]   acc;
    logic [DW-1:0]      a_buf [N];
    logic [DW-1:0]      b_buf [N];
    logic [DW-1:0]      c_buf [N][N];
    logic [H*DW-1:0]    p_row [H];
    logic [H*DW-1:0]    p_row_nxt [H];

    logic [2*DW-1:0]    prod;
    logic [ACC_W-1:0]   sum_full;
    logic [DW-1:0]      c_val;
    logic [CW-1:0]      r0, r1, c0, c1;
    logic [DW-1:0]      w00, w01, w10, w11, mx, pool_val;
    logic [DW+1:0]      avg_sum;
    logic [CW-1:0]      a_row_sel, b_col_sel;
    logic [HW-1:0]      w_row_sel;
    logic               k_last, j_last, i_last, pc_last, pr_last, w_last;

    assign k_last  = (k == CW'(N-1));
    assign j_last  = (j == CW'(N-1));
    assign i_last  = (i == CW'(N-1));
    assign pc_last = (pc == HW'(H-1));
    assign pr_last = (pr == HW'(H-1));
    assign w_last  = (wrow == HW'(H-1));

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign rd_en_a = (state == RD_A);
    assign rd_en_b = (state == RD_B);
    assign wr_en_c = (state == WRITE);

    // Next-state sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = RD_A;
            RD_A:  state_nxt = CAP_A;
            CAP_A: state_nxt = RD_B;
            RD_B:  state_nxt = CAP_B;
            CAP_B: state_nxt = MAC;
            MAC: begin
                if (k_last) begin
                    if (!j_last)      state_nxt = RD_B;
                    else if (!i_last) state_nxt = RD_A;
                    else              state_nxt = POOL;
                end
            end
            POOL:  if (pr_last && pc_last) state_nxt = WRITE;
            WRITE: if (w_last) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // MAC datapath: full sum including this cycle's product, saturated to DW bits.
    always_comb begin
        prod     = a_buf[k] * b_buf[k];
        sum_full = acc + ACC_W'(prod);
        c_val    = (sum_full > SAT_MAX) ? {DW{1'b1}} : sum_full[DW-1:0];
    end

    // 2x2 pooling window and the pooled-row image including the element produced this cycle.
    always_comb begin
        r0 = CW'({pr, 1'b0});
        r1 = CW'({pr, 1'b1});
        c0 = CW'({pc, 1'b0});
        c1 = CW'({pc, 1'b1});
        w00 = c_buf[r0][c0];
        w01 = c_buf[r0][c1];
        w10 = c_buf[r1][c0];
        w11 = c_buf[r1][c1];
        avg_sum = {2'b00, w00} + {2'b00, w01} + {2'b00, w10} + {2'b00, w11};
        mx = w00;
        if (w01 > mx) mx = w01;
        if (w10 > mx) mx = w10;
        if (w11 > mx) mx = w11;
        pool_val = mode ? mx : avg_sum[DW+1:2];
        p_row_nxt = p_row;
        if (state == POOL) p_row_nxt[pr][int'(pc)*DW +: DW] = pool_val;
    end

    // Row/column/write-row indices used by the cycle about to be entered.
    always_comb begin
        a_row_sel = (state == IDLE) ? '0 : i + CW'(1);
        b_col_sel = (state == MAC)  ? j + CW'(1) : j;
        w_row_sel = (state == POOL) ? '0 : wrow + HW'(1);
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Counters, operand buffers, accumulator and result storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i    <= '0;
            j    <= '0;
            k    <= '0;
            pr   <= '0;
            pc   <= '0;
            wrow <= '0;
            mode <= 1'b0;
            acc  <= '0;
            for (int x = 0; x < N; x++) begin
                a_buf[x] <= '0;
                b_buf[x] <= '0;
                for (int y = 0; y < N; y++) c_buf[x][y] <= '0;
            end
            for (int x = 0; x < H; x++) p_row[x] <= '0;
        end else begin
            p_row <= p_row_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode <= pool_mode;
                        i    <= '0;
                        j    <= '0;
                        pr   <= '0;
                        pc   <= '0;
                        wrow <= '0;
                    end
                end
                CAP_A: for (int x = 0; x < N; x++) a_buf[x] <= rd_data_a[x*DW +: DW];
                CAP_B: begin
                    for (int x = 0; x < N; x++) b_buf[x] <= rd_data_b[x*DW +: DW];
                    acc <= '0;
                    k   <= '0;
                end
                MAC: begin
                    acc <= sum_full;
                    k   <= k + CW'(1);
                    if (k_last) begin
                        c_buf[i][j] <= c_val;
                        k <= '0;
                        if (!j_last) begin
                            j <= j + CW'(1);
                        end else if (!i_last) begin
                            j <= '0;
                            i <= i + CW'(1);
                        end
                    end
                end
                POOL: begin
                    pc <= pc + HW'(1);
                    if (pc_last) begin
                        pc <= '0;
                        pr <= pr + HW'(1);
                    end
                end
                WRITE: wrow <= wrow + HW'(1);
                default: ;
            endcase
        end
    end

    // Address/data outputs load on entry to their strobe state and hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            wr_addr_c <= '0;
            wr_data_c <= '0;
        end else begin
            if (state_nxt == RD_A)  rd_addr_a <= BASE_A + ADDR_W'(a_row_sel);
            if (state_nxt == RD_B)  rd_addr_b <= BASE_B + ADDR_W'(b_col_sel);
            if (state_nxt == WRITE) begin
                wr_addr_c <= BASE_C + ADDR_W'(w_row_sel);
                wr_data_c <= p_row_nxt[w_row_sel];
            end
        end
    end
endmodule

// File: tb/tb_matmul_pool_engine.sv
// Directed bench for matmul_pool_engine: N=4 instance for the main runs,
// N=2 instance for the small-matrix case. Memories respond with 1-cycle latency.
module tb_matmul_pool_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    // N=4 instance
    logic        start4, mode4, busy4, done4, rd_en_a4, rd_en_b4, wr_en_c4;
    logic [9:0]  rd_addr_a4, rd_addr_b4, wr_addr_c4;
    logic [31:0] rd_data_a4 = '0, rd_data_b4 = '0;
    logic [15:0] wr_data_c4;

    matmul_pool_engine #(.N(4)) dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .pool_mode(mode4),
        .busy(busy4), .done(done4),
        .rd_en_a(rd_en_a4), .rd_addr_a(rd_addr_a4), .rd_data_a(rd_data_a4),
        .rd_en_b(rd_en_b4), .rd_addr_b(rd_addr_b4), .rd_data_b(rd_data_b4),
        .wr_en_c(wr_en_c4), .wr_addr_c(wr_addr_c4), .wr_data_c(wr_data_c4)
    );

    // N=2 instance
    logic        start2, mode2, busy2, done2, rd_en_a2, rd_en_b2, wr_en_c2;
    logic [9:0]  rd_addr_a2, rd_addr_b2, wr_addr_c2;
    logic [15:0] rd_data_a2 = '0, rd_data_b2 = '0;
    logic [7:0]  wr_data_c2;

    matmul_pool_engine #(.N(2)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .pool_mode(mode2),
        .busy(busy2), .done(done2),
        .rd_en_a(rd_en_a2), .rd_addr_a(rd_addr_a2), .rd_data_a(rd_data_a2),
        .rd_en_b(rd_en_b2), .rd_addr_b(rd_addr_b2), .rd_data_b(rd_data_b2),
        .wr_en_c(wr_en_c2), .wr_addr_c(wr_addr_c2), .wr_data_c(wr_data_c2)
    );

    logic [31:0] mem_a4 [4];
    logic [31:0] mem_b4 [4];
    logic [15:0] mem_a2 [2];
    logic [15:0] mem_b2 [2];

    // Expected start-accept-to-done latency, counting the accept cycle and the done cycle.
    localparam int LAT4 = 1 + 4*(2 + 4*(4+2)) + 4 + 2 + 1;
    localparam int LAT2 = 1 + 2*(2 + 2*(2+2)) + 1 + 1 + 1;

    int n_checks = 0;
    int n_errors = 0;
    int wr_n4 = 0, done_n4 = 0, wr_n2 = 0, done_n2 = 0, clash_n = 0;
    logic [9:0]  wa4 [64];
    logic [15:0] wd4 [64];
    logic [9:0]  wa2 [16];
    logic [7:0]  wd2 [16];

    // Memory read models with one cycle of latency.
    always @(posedge clk) begin
        if (rd_en_a4) rd_data_a4 <= mem_a4[rd_addr_a4[1:0]];
        if (rd_en_b4) rd_data_b4 <= mem_b4[rd_addr_b4[1:0]];
        if (rd_en_a2) rd_data_a2 <= mem_a2[rd_addr_a2[0]];
        if (rd_en_b2) rd_data_b2 <= mem_b2[rd_addr_b2[0]];
    end

    // Write/done capture and strobe-overlap monitor.
    always @(posedge clk) begin
        if (wr_en_c4) begin
            wa4[wr_n4 % 64] <= wr_addr_c4;
            wd4[wr_n4 % 64] <= wr_data_c4;
            wr_n4 <= wr_n4 + 1;
        end
        if (done4) done_n4 <= done_n4 + 1;
        if (wr_en_c2) begin
            wa2[wr_n2 % 16] <= wr_addr_c2;
            wd2[wr_n2 % 16] <= wr_data_c2;
            wr_n2 <= wr_n2 + 1;
        end
        if (done2) done_n2 <= done_n2 + 1;
        if ((rd_en_a4 & rd_en_b4) | (rd_en_a4 & wr_en_c4) | (rd_en_b4 & wr_en_c4) |
            (rd_en_a2 & rd_en_b2) | (rd_en_a2 & wr_en_c2) | (rd_en_b2 & wr_en_c2))
            clash_n <= clash_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One N=4 run, started in the current cycle (caller is at a negedge with the DUT idle).
    task automatic run4(input logic mode, input int retrig,
                        output int lat, output int nw, output int nd, output int w0);
        int d0;
        w0 = wr_n4;
        d0 = done_n4;
        start4 = 1'b1;
        mode4  = mode;
        check("accept_busy", busy4, 0);
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
            start4 = (lat == retrig);
            mode4  = (lat == retrig) ? ~mode : mode;
            if (lat == 2) check("busy_after_accept", busy4, 1);
        end while (!done4 && lat < 400);
        start4 = 1'b0;
        @(negedge clk);
        check("busy_after_done", busy4, 0);
        check("done_one_cycle", done4, 0);
        nw = wr_n4 - w0;
        nd = done_n4 - d0;
    endtask

    task automatic expect4(input string tag, input int lat, input int nw, input int nd,
                           input int w0, input logic [15:0] d0, input logic [15:0] d1);
        check({tag, "_lat"}, lat, LAT4);
        check({tag, "_nwr"}, nw, 2);
        check({tag, "_ndone"}, nd, 1);
        check({tag, "_addr0"}, wa4[w0 % 64], 10'h200);
        check({tag, "_data0"}, wd4[w0 % 64], d0);
        check({tag, "_addr1"}, wa4[(w0+1) % 64], 10'h201);
        check({tag, "_data1"}, wd4[(w0+1) % 64], d1);
    endtask

    task automatic load_ident4();
        for (int r = 0; r < 4; r++) begin
            mem_a4[r] = 32'h1 << (8*r);
            mem_b4[r] = {4{8'(r+1)}};
        end
    endtask

    initial begin
        int lat, nw, nd, w0, d0;
        rstn = 1'b0;
        start4 = 1'b0; mode4 = 1'b0;
        start2 = 1'b0; mode2 = 1'b0;
        load_ident4();
        mem_a2[0] = {8'd2, 8'd1}; mem_a2[1] = {8'd4, 8'd3};
        mem_b2[0] = {8'd7, 8'd5}; mem_b2[1] = {8'd8, 8'd6};
        repeat (3) @(negedge clk);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_strobes", {rd_en_a4, rd_en_b4, wr_en_c4}, 0);
        check("rst_wr_addr", wr_addr_c4, 0);
        check("rst_wr_data", wr_data_c4, 0);
        rstn = 1'b1;
        @(negedge clk);

        // A=I, B[r][c]=c+1: C[r][c]=c+1, avg windows (1,2,1,2)->1 and (3,4,3,4)->3
        run4(1'b0, 0, lat, nw, nd, w0);
        expect4("ident_avg", lat, nw, nd, w0, 16'h0301, 16'h0301);
        run4(1'b1, 0, lat, nw, nd, w0);
        expect4("ident_max", lat, nw, nd, w0, 16'h0402, 16'h0402);

        // All 16s: each dot product is 1024, saturated to 255
        for (int r = 0; r < 4; r++) begin
            mem_a4[r] = 32'h10101010;
            mem_b4[r] = 32'h10101010;
        end
        run4(1'b0, 0, lat, nw, nd, w0);
        expect4("sat_avg", lat, nw, nd, w0, 16'hFFFF, 16'hFFFF);
        run4(1'b1, 0, lat, nw, nd, w0);
        expect4("sat_max", lat, nw, nd, w0, 16'hFFFF, 16'hFFFF);

        // Start (with flipped mode) at cycle 10 is ignored; next run starts right after done
        load_ident4();
        run4(1'b0, 10, lat, nw, nd, w0);
        expect4("retrig_ignored", lat, nw, nd, w0, 16'h0301, 16'h0301);
        run4(1'b1, 0, lat, nw, nd, w0);
        expect4("back_to_back", lat, nw, nd, w0, 16'h0402, 16'h0402);

        // Reset at cycle 50 of a run
        w0 = wr_n4;
        d0 = done_n4;
        start4 = 1'b1;
        mode4  = 1'b0;
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            start4 = 1'b0;
        end
        rstn = 1'b0;
        #1;
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_strobes", {rd_en_a4, rd_en_b4, wr_en_c4}, 0);
        check("abort_rd_addr_a", rd_addr_a4, 0);
        check("abort_rd_addr_b", rd_addr_b4, 0);
        check("abort_wr_addr", wr_addr_c4, 0);
        check("abort_wr_data", wr_data_c4, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (150) @(negedge clk);
        check("abort_no_write", wr_n4 - w0, 0);
        check("abort_no_done", done_n4 - d0, 0);
        run4(1'b0, 0, lat, nw, nd, w0);
        expect4("after_abort", lat, nw, nd, w0, 16'h0301, 16'h0301);

        // N=2: C=[[19,22],[43,50]] -> avg 33, max 50
        for (int m = 0; m < 2; m++) begin
            w0 = wr_n2;
            start2 = 1'b1;
            mode2  = m[0];
            lat = 1;
            do begin
                @(negedge clk);
                lat++;
                start2 = 1'b0;
            end while (!done2 && lat < 200);
            @(negedge clk);
            check("n2_lat", lat, LAT2);
            check("n2_nwr", wr_n2 - w0, 1);
            check("n2_addr", wa2[w0 % 16], 10'h200);
            check("n2_data", wd2[w0 % 16], (m == 0) ? 8'd33 : 8'd50);
            check("n2_busy_idle", busy2, 0);
        end

        check("strobe_overlap", clash_n, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
